// File: rtl/gbuf_port_arbiter.sv
// ============================================================================
// Module      : gbuf_port_arbiter (with helper gbuf_rr_arb)
// Description : Shares the single-read/single-write global buffer SRAM
//               between NUM_RD read requesters and NUM_WR write requesters.
//               Each port has its own round-robin arbiter that grants one
//               requester per cycle. Read data returns one cycle after the
//               grant, tagged by a registered one-hot valid.
//               Optional macro GBUF_RAW_BYPASS_EN: forwards the write data
//               to a read that hits the same address in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Round-robin arbiter: the search starts at the pointer and wraps modulo N.
module gbuf_rr_arb #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt,
  output logic         o_valid
);

  localparam int                 c_PTR_W = $clog2(N);
  localparam logic [c_PTR_W:0]   c_N     = (c_PTR_W + 1)'(N);

  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W-1:0] w_off;
  logic [c_PTR_W-1:0] w_win;
  logic [c_PTR_W-1:0] w_nxt;
  logic [c_PTR_W:0]   w_sum;
  logic [c_PTR_W:0]   w_inc;
  logic [2*N-1:0]     w_req2;
  logic [N-1:0]       w_rot;

  // Rotate the request vector so that bit 0 is the requester at the pointer.
  assign w_req2  = {i_req, i_req};
  assign w_rot   = N'(w_req2 >> r_ptr);
  assign o_valid = |i_req;

  // Offset (from the pointer) of the first active requester.
  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = c_PTR_W'(k);
      end
    end
  end

  // Winner index and next pointer, both reduced modulo N.
  assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win = c_PTR_W'((w_sum >= c_N) ? (w_sum - c_N) : w_sum);
  assign w_inc = {1'b0, w_win} + (c_PTR_W + 1)'(1);
  assign w_nxt = c_PTR_W'((w_inc == c_N) ? {(c_PTR_W + 1){1'b0}} : w_inc);

  // One-hot grant decode of the winner.
  always_comb begin
    o_gnt = '0;
    for (int i = 0; i < N; i++) begin
      o_gnt[i] = o_valid && (w_win == c_PTR_W'(i));
    end
  end

  // Advance the pointer past the winner; hold it when nobody requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (o_valid) begin
      r_ptr <= w_nxt;
    end
  end

endmodule

module gbuf_port_arbiter #(
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_req_addr,
  output logic [NUM_RD-1:0]        rd_gnt,
  output logic [NUM_RD-1:0]        rd_rsp_valid,
  output logic [DATA_W-1:0]        rd_rsp_data,
  input  logic [NUM_WR-1:0]        wr_req,
  input  logic [NUM_WR*ADDR_W-1:0] wr_req_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_req_data,
  output logic [NUM_WR-1:0]        wr_gnt,
  output logic                     sram_rd_valid,
  output logic [ADDR_W-1:0]        sram_rd_addr,
  input  logic [DATA_W-1:0]        sram_do,
  output logic                     sram_wr_valid,
  output logic [ADDR_W-1:0]        sram_wr_addr,
  output logic [DATA_W-1:0]        sram_di
);

  logic [NUM_RD-1:0] r_rsp_tag;

  gbuf_rr_arb #(.N(NUM_RD)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (rd_req),
    .o_gnt   (rd_gnt),
    .o_valid (sram_rd_valid)
  );

  gbuf_rr_arb #(.N(NUM_WR)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (wr_req),
    .o_gnt   (wr_gnt),
    .o_valid (sram_wr_valid)
  );

  // AND-OR mux of the winning read address; zero when nothing is granted.
  always_comb begin
    sram_rd_addr = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      sram_rd_addr = sram_rd_addr | ({ADDR_W{rd_gnt[i]}} & rd_req_addr[i*ADDR_W +: ADDR_W]);
    end
  end

  // AND-OR mux of the winning write address and data; zero when idle.
  always_comb begin
    sram_wr_addr = '0;
    sram_di      = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      sram_wr_addr = sram_wr_addr | ({ADDR_W{wr_gnt[i]}} & wr_req_addr[i*ADDR_W +: ADDR_W]);
      sram_di      = sram_di      | ({DATA_W{wr_gnt[i]}} & wr_req_data[i*DATA_W +: DATA_W]);
    end
  end

  // Remember who was granted so the SRAM data one cycle later is tagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_tag <= '0;
    end else begin
      r_rsp_tag <= rd_gnt;
    end
  end

  assign rd_rsp_valid = r_rsp_tag;

`ifdef GBUF_RAW_BYPASS_EN
  logic              w_coll;
  logic              r_coll;
  logic [DATA_W-1:0] r_byp_data;

  assign w_coll = sram_rd_valid & sram_wr_valid & (sram_rd_addr == sram_wr_addr);

  // Capture a same-address read/write so the response carries the new word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_coll     <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_coll     <= w_coll;
      r_byp_data <= sram_di;
    end
  end

  assign rd_rsp_data = r_coll ? r_byp_data : sram_do;
`else
  // The SRAM is read-first, so a colliding read returns the old word.
  assign rd_rsp_data = sram_do;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gbuf_port_arbiter.sv
// ============================================================================
// Module      : tb_gbuf_port_arbiter
// Description : Self-checking bench for gbuf_port_arbiter with a read-first
//               SRAM stand-in and a behavioural arbitration/memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gbuf_port_arbiter;

  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 1 << ADDR_W;

`ifdef GBUF_RAW_BYPASS_EN
  localparam logic [DATA_W-1:0] c_COLL_EXP = {16{8'h55}};
`else
  localparam logic [DATA_W-1:0] c_COLL_EXP = '0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD-1:0]        rd_req;
  logic [NUM_RD*ADDR_W-1:0] rd_req_addr;
  logic [NUM_RD-1:0]        rd_gnt;
  logic [NUM_RD-1:0]        rd_rsp_valid;
  logic [DATA_W-1:0]        rd_rsp_data;
  logic [NUM_WR-1:0]        wr_req;
  logic [NUM_WR*ADDR_W-1:0] wr_req_addr;
  logic [NUM_WR*DATA_W-1:0] wr_req_data;
  logic [NUM_WR-1:0]        wr_gnt;
  logic                     sram_rd_valid;
  logic [ADDR_W-1:0]        sram_rd_addr;
  logic [DATA_W-1:0]        sram_do;
  logic                     sram_wr_valid;
  logic [ADDR_W-1:0]        sram_wr_addr;
  logic [DATA_W-1:0]        sram_di;

  gbuf_port_arbiter #(
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_req_addr(rd_req_addr), .rd_gnt(rd_gnt),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_req(wr_req), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_gnt(wr_gnt),
    .sram_rd_valid(sram_rd_valid), .sram_rd_addr(sram_rd_addr), .sram_do(sram_do),
    .sram_wr_valid(sram_wr_valid), .sram_wr_addr(sram_wr_addr), .sram_di(sram_di)
  );

  always #5 clk = ~clk;

  // SRAM stand-in: read-first, one-cycle read latency, plus a preload port.
  logic [DATA_W-1:0] sram_mem [0:DEPTH-1] = '{default: '0};
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;
  always @(posedge clk) begin
    sram_do <= sram_mem[sram_rd_addr];
    if (sram_wr_valid) sram_mem[sram_wr_addr] <= sram_di;
    else if (pl_en)    sram_mem[pl_addr]      <= pl_data;
  end

  // Requester-side stimulus
  logic [NUM_RD-1:0] t_rd_req;
  logic [ADDR_W-1:0] t_rd_addr [NUM_RD];
  logic [NUM_WR-1:0] t_wr_req;
  logic [ADDR_W-1:0] t_wr_addr [NUM_WR];
  logic [DATA_W-1:0] t_wr_data [NUM_WR];

  // Expected outputs for the current cycle
  logic [NUM_RD-1:0] e_rd_gnt, e_rsp_valid;
  logic [NUM_WR-1:0] e_wr_gnt;
  logic [ADDR_W-1:0] e_rd_addr, e_wr_addr;
  logic [DATA_W-1:0] e_rsp_data, e_wr_data;

  // Reference model state
  int                m_rd_ptr, m_wr_ptr;
  logic [NUM_RD-1:0] m_pend_tag;
  logic [DATA_W-1:0] m_pend_data;
  logic [DATA_W-1:0] m_mem [0:DEPTH-1];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic model_reset();
    m_rd_ptr   = 0;
    m_wr_ptr   = 0;
    m_pend_tag = '0;
  endtask

  task automatic clear_stim();
    t_rd_req = '0;
    t_wr_req = '0;
    for (int i = 0; i < NUM_RD; i++) t_rd_addr[i] = '0;
    for (int i = 0; i < NUM_WR; i++) begin t_wr_addr[i] = '0; t_wr_data[i] = '0; end
  endtask

  // Apply stimulus for one cycle and derive this cycle's expected outputs.
  task automatic step();
    int w;
    int v;
    @(negedge clk);
    rd_req = t_rd_req;
    wr_req = t_wr_req;
    for (int i = 0; i < NUM_RD; i++) rd_req_addr[i*ADDR_W +: ADDR_W] = t_rd_addr[i];
    for (int i = 0; i < NUM_WR; i++) begin
      wr_req_addr[i*ADDR_W +: ADDR_W] = t_wr_addr[i];
      wr_req_data[i*DATA_W +: DATA_W] = t_wr_data[i];
    end
    #1;
    e_rsp_valid = m_pend_tag;
    e_rsp_data  = m_pend_data;
    w = -1;
    for (int k = 0; k < NUM_RD; k++)
      if (w < 0 && t_rd_req[(m_rd_ptr + k) % NUM_RD]) w = (m_rd_ptr + k) % NUM_RD;
    v = -1;
    for (int k = 0; k < NUM_WR; k++)
      if (v < 0 && t_wr_req[(m_wr_ptr + k) % NUM_WR]) v = (m_wr_ptr + k) % NUM_WR;
    e_rd_gnt = '0; e_rd_addr = '0;
    e_wr_gnt = '0; e_wr_addr = '0; e_wr_data = '0;
    if (w >= 0) begin e_rd_gnt[w] = 1'b1; e_rd_addr = t_rd_addr[w]; m_rd_ptr = (w + 1) % NUM_RD; end
    if (v >= 0) begin
      e_wr_gnt[v] = 1'b1; e_wr_addr = t_wr_addr[v]; e_wr_data = t_wr_data[v];
      m_wr_ptr = (v + 1) % NUM_WR;
    end
    m_pend_tag = e_rd_gnt;
    if (w >= 0) begin
      m_pend_data = m_mem[e_rd_addr];
`ifdef GBUF_RAW_BYPASS_EN
      if (v >= 0 && e_wr_addr == e_rd_addr) m_pend_data = e_wr_data;
`endif
    end
    if (v >= 0) m_mem[e_wr_addr] = e_wr_data;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    rd_req = '0; wr_req = '0;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    m_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
    m_pend_tag = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_stim();
    rd_req = '0; wr_req = '0; rd_req_addr = '0; wr_req_addr = '0; wr_req_data = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (rd_rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=00", rd_rsp_valid); end
    n_cmp++; if (rd_gnt !== '0 || wr_gnt !== '0) begin n_fail++; $display("FAIL reset_gnt got rd=%b wr=%b exp=00", rd_gnt, wr_gnt); end
    n_cmp++; if ({sram_rd_valid, sram_wr_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_sram_valid got=%b exp=00", {sram_rd_valid, sram_wr_valid}); end
    n_cmp++; if (sram_rd_addr !== '0 || sram_wr_addr !== '0 || sram_di !== '0) begin n_fail++; $display("FAIL reset_idle_bus got ra=%h wa=%h di=%h exp=0", sram_rd_addr, sram_wr_addr, sram_di); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    logic [NUM_RD-1:0] exp_g;
    clear_stim();
    t_rd_req = 2'b11; t_rd_addr[0] = 10'h010; t_rd_addr[1] = 10'h020;
    for (int c = 0; c < 6; c++) begin
      step();
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (rd_gnt !== exp_g) begin n_fail++; $display("FAIL b2b_gnt cyc=%0d got=%b exp=%b", c, rd_gnt, exp_g); end
      n_cmp++; if (sram_rd_addr !== ((c % 2 == 0) ? 10'h010 : 10'h020)) begin n_fail++; $display("FAIL b2b_addr cyc=%0d got=%h", c, sram_rd_addr); end
      if (c > 0) begin
        n_cmp++; if (rd_rsp_valid !== ~exp_g) begin n_fail++; $display("FAIL b2b_rsp_valid cyc=%0d got=%b exp=%b", c, rd_rsp_valid, ~exp_g); end
        n_cmp++; if (rd_rsp_data !== e_rsp_data) begin n_fail++; $display("FAIL b2b_rsp_data cyc=%0d got=%h exp=%h", c, rd_rsp_data, e_rsp_data); end
      end
    end
    t_rd_req = '0;
    step();
    n_cmp++; if (rd_rsp_valid !== 2'b10) begin n_fail++; $display("FAIL b2b_last_rsp got=%b exp=10", rd_rsp_valid); end
  endtask

  task automatic test_single_read();
    preload(10'h005, {16{8'hAA}});
    clear_stim();
    t_rd_req = 2'b01; t_rd_addr[0] = 10'h005;
    step();
    n_cmp++; if (rd_gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt got=%b exp=01", rd_gnt); end
    n_cmp++; if (sram_rd_addr !== 10'h005 || sram_rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_addr got=%h v=%b exp=005 v=1", sram_rd_addr, sram_rd_valid); end
    t_rd_req = '0;
    step();
    n_cmp++; if (rd_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid got=%b exp=01", rd_rsp_valid); end
    n_cmp++; if (rd_rsp_data !== {16{8'hAA}}) begin n_fail++; $display("FAIL single_rsp_data got=%h exp=aa..aa", rd_rsp_data); end
  endtask

  task automatic test_write_then_read();
    clear_stim();
    t_wr_req = 2'b11;
    t_wr_addr[0] = 10'h030; t_wr_data[0] = {16{8'h11}};
    t_wr_addr[1] = 10'h031; t_wr_data[1] = {16{8'h22}};
    step();
    n_cmp++; if (wr_gnt !== 2'b01 || sram_wr_addr !== 10'h030 || sram_di !== {16{8'h11}}) begin n_fail++; $display("FAIL wr0 got gnt=%b a=%h d=%h", wr_gnt, sram_wr_addr, sram_di); end
    t_wr_req = 2'b10;
    step();
    n_cmp++; if (wr_gnt !== 2'b10 || sram_wr_addr !== 10'h031 || sram_di !== {16{8'h22}}) begin n_fail++; $display("FAIL wr1 got gnt=%b a=%h d=%h", wr_gnt, sram_wr_addr, sram_di); end
    t_wr_req = '0;
    t_rd_req = 2'b01; t_rd_addr[0] = 10'h030;
    step();
    t_rd_req = 2'b10; t_rd_addr[1] = 10'h031;
    step();
    n_cmp++; if (rd_rsp_valid !== 2'b01 || rd_rsp_data !== {16{8'h11}}) begin n_fail++; $display("FAIL rd_after_wr0 got v=%b d=%h exp v=01 d=11..11", rd_rsp_valid, rd_rsp_data); end
    t_rd_req = '0;
    step();
    n_cmp++; if (rd_rsp_valid !== 2'b10 || rd_rsp_data !== {16{8'h22}}) begin n_fail++; $display("FAIL rd_after_wr1 got v=%b d=%h exp v=10 d=22..22", rd_rsp_valid, rd_rsp_data); end
  endtask

  task automatic test_collision();
    clear_stim();
    t_wr_req = 2'b01; t_wr_addr[0] = 10'h040; t_wr_data[0] = {16{8'h55}};
    t_rd_req = 2'b01; t_rd_addr[0] = 10'h040;
    step();
    n_cmp++; if (rd_gnt !== 2'b01 || wr_gnt !== 2'b01) begin n_fail++; $display("FAIL coll_both_gnt got rd=%b wr=%b exp 01/01", rd_gnt, wr_gnt); end
    clear_stim();
    step();
    n_cmp++; if (rd_rsp_valid !== 2'b01 || rd_rsp_data !== c_COLL_EXP) begin n_fail++; $display("FAIL coll_data got v=%b d=%h exp=%h", rd_rsp_valid, rd_rsp_data, c_COLL_EXP); end
    t_rd_req = 2'b10; t_rd_addr[1] = 10'h040;
    step();
    t_rd_req = '0;
    step();
    n_cmp++; if (rd_rsp_data !== {16{8'h55}}) begin n_fail++; $display("FAIL coll_reread got=%h exp=55..55", rd_rsp_data); end
  endtask

  task automatic test_random();
    clear_stim();
    for (int c = 0; c < 400; c++) begin
      step();
      n_cmp++; if (rd_gnt !== e_rd_gnt) begin n_fail++; $display("FAIL rnd_rd_gnt cyc=%0d got=%b exp=%b", c, rd_gnt, e_rd_gnt); end
      n_cmp++; if (wr_gnt !== e_wr_gnt) begin n_fail++; $display("FAIL rnd_wr_gnt cyc=%0d got=%b exp=%b", c, wr_gnt, e_wr_gnt); end
      n_cmp++; if (sram_rd_valid !== (|e_rd_gnt) || sram_rd_addr !== e_rd_addr) begin n_fail++; $display("FAIL rnd_rd_bus cyc=%0d got v=%b a=%h exp v=%b a=%h", c, sram_rd_valid, sram_rd_addr, |e_rd_gnt, e_rd_addr); end
      n_cmp++; if (sram_wr_valid !== (|e_wr_gnt) || sram_wr_addr !== e_wr_addr) begin n_fail++; $display("FAIL rnd_wr_bus cyc=%0d got v=%b a=%h exp v=%b a=%h", c, sram_wr_valid, sram_wr_addr, |e_wr_gnt, e_wr_addr); end
      n_cmp++; if (sram_di !== e_wr_data) begin n_fail++; $display("FAIL rnd_wr_data cyc=%0d got=%h exp=%h", c, sram_di, e_wr_data); end
      n_cmp++; if (rd_rsp_valid !== e_rsp_valid) begin n_fail++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", c, rd_rsp_valid, e_rsp_valid); end
      if (e_rsp_valid != '0) begin
        n_cmp++; if (rd_rsp_data !== e_rsp_data) begin n_fail++; $display("FAIL rnd_rsp_data cyc=%0d got=%h exp=%h", c, rd_rsp_data, e_rsp_data); end
      end
      // Waiting requesters keep req/addr stable (occasionally withdrawing);
      // idle or just-granted requesters draw a new request.
      for (int i = 0; i < NUM_RD; i++) begin
        if (t_rd_req[i] && !e_rd_gnt[i]) begin
          if ($urandom_range(0, 7) == 0) t_rd_req[i] = 1'b0;
        end else begin
          t_rd_req[i]  = ($urandom_range(0, 3) != 0);
          t_rd_addr[i] = 10'h100 + ADDR_W'($urandom_range(0, 7));
        end
      end
      for (int i = 0; i < NUM_WR; i++) begin
        if (t_wr_req[i] && !e_wr_gnt[i]) begin
          if ($urandom_range(0, 7) == 0) t_wr_req[i] = 1'b0;
        end else begin
          t_wr_req[i]  = ($urandom_range(0, 3) != 0);
          t_wr_addr[i] = 10'h100 + ADDR_W'($urandom_range(0, 7));
          t_wr_data[i] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
    clear_stim();
    step();
  endtask

  task automatic test_drop_req();
    clear_stim();
    t_rd_req = 2'b01; t_rd_addr[0] = 10'h050; t_rd_addr[1] = 10'h060;
    step();
    t_rd_req = 2'b11;
    step();
    n_cmp++; if (rd_gnt !== 2'b10) begin n_fail++; $display("FAIL drop_wait_gnt got=%b exp=10", rd_gnt); end
    t_rd_req = 2'b10;
    step();
    n_cmp++; if (rd_gnt !== 2'b10) begin n_fail++; $display("FAIL drop_only_r1 got=%b exp=10", rd_gnt); end
    n_cmp++; if (rd_rsp_valid !== 2'b10) begin n_fail++; $display("FAIL drop_rsp1 got=%b exp=10", rd_rsp_valid); end
    t_rd_req = '0;
    step();
    n_cmp++; if (rd_rsp_valid !== 2'b10) begin n_fail++; $display("FAIL drop_rsp2 got=%b exp=10", rd_rsp_valid); end
    step();
    n_cmp++; if (rd_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL drop_rsp3 got=%b exp=00", rd_rsp_valid); end
  endtask

  task automatic test_reset_midflight();
    clear_stim();
    t_rd_req = 2'b10; t_rd_addr[0] = 10'h010; t_rd_addr[1] = 10'h020;
    t_wr_req = 2'b01; t_wr_addr[0] = 10'h070; t_wr_data[0] = {16{8'h77}};
    t_wr_addr[1] = 10'h071; t_wr_data[1] = {16{8'h78}};
    step();
    n_cmp++; if (rd_gnt !== 2'b10 || wr_gnt !== 2'b01) begin n_fail++; $display("FAIL midrst_pre_gnt got rd=%b wr=%b exp 10/01", rd_gnt, wr_gnt); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_req = '0; wr_req = '0;
    #1;
    n_cmp++; if (rd_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL midrst_during got=%b exp=00", rd_rsp_valid); end
    @(posedge clk);
    #1;
    n_cmp++; if (rd_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL midrst_held got=%b exp=00", rd_rsp_valid); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    t_rd_req = 2'b11; t_wr_req = 2'b11;
    step();
    n_cmp++; if (rd_gnt !== 2'b01) begin n_fail++; $display("FAIL midrst_rd_ptr got=%b exp=01", rd_gnt); end
    n_cmp++; if (wr_gnt !== 2'b01) begin n_fail++; $display("FAIL midrst_wr_ptr got=%b exp=01", wr_gnt); end
    n_cmp++; if (rd_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL midrst_stale got=%b exp=00", rd_rsp_valid); end
    clear_stim();
    step();
    n_cmp++; if (rd_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL midrst_next_rsp got=%b exp=01", rd_rsp_valid); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_pend_data = '0;
    model_reset();
    test_reset();
    test_back_to_back();
    test_single_read();
    test_write_then_read();
    test_collision();
    test_random();
    test_drop_req();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
